time_bus_reader: RTL and testbench
==================================

# time_bus_reader

Read-side master for the shared counter databus. Periodically asserts the enable of the seconds, minutes and hours counters one at a time, captures the 6-bit value each drives onto the OR-combined `databus`, and converts it to two BCD digits. Publishes all six digits atomically to the display driver, with a frame strobe and a range-error flag. Sits between the counter bank and the 7-segment/LCD formatter.

## Interface

- `SCAN_DIV`, default 1000: idle cycles between scans, legal range 1..65535.
- `HOUR_MAX`, default 23: largest legal hour value; 12 for 12-hour builds.
- `clk` input, 1 bit: the single clock for the block.
- `clear` input, 1 bit: synchronous, active-high reset.
- `freeze` input, 1 bit: when high, no new scan starts; a scan already in progress completes.
- `databus` input, 6 bits: OR of all counters' gated outputs. Zero when no enable is high.
- `en_sec` output, 1 bit: enable to the seconds counter's databus gate.
- `en_min` output, 1 bit: enable to the minutes counter's databus gate.
- `en_hr` output, 1 bit: enable to the hours counter's databus gate.
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`, `hr_ones`, `hr_tens` output, 4 bits each: BCD digits.
- `frame_valid` output, 1 bit: one-cycle pulse when the digits update.
- `range_err` output, 1 bit: high when any field in the last published frame was out of range.
- `busy` output, 1 bit: high while in any state other than IDLE.

## Operation

- States: IDLE, SEC0, SEC1, MIN0, MIN1, HR0, HR1, UPDATE.
- IDLE:
  - 16-bit divider counts 0..SCAN_DIV-1.
  - When the divider is at SCAN_DIV-1 and `freeze`=0, go to SEC0 and reset the divider to 0.
  - When the divider is at SCAN_DIV-1 and `freeze`=1, hold IDLE with the divider saturated at SCAN_DIV-1.
  - The scan starts on the first cycle `freeze` is low.
- SEC0/SEC1: `en_sec`=1.
  - SEC0 is the settle cycle.
  - On the clock edge leaving SEC1, `databus` is captured into the shadow register `sh_sec`.
- MIN0/MIN1 and HR0/HR1: same pattern, using `en_min`/`sh_min` and `en_hr`/`sh_hr`.
  - The hour capture keeps all 6 bits.
- Enables are registered outputs decoded from state. At most one is high in any cycle; all are low in IDLE and UPDATE.
- UPDATE:
  - Each shadow value v (0..63) is converted to tens = v/10 and ones = v mod 10, using a compare-subtract chain with thresholds 60/50/40/30/20/10.
  - tens is zero-extended to 4 bits.
  - All six digit outputs load on the same edge.
  - `frame_valid`=1 for exactly this one cycle.
  - `range_err` loads (sh_sec>59)|(sh_min>59)|(sh_hr>HOUR_MAX).
  - Out-of-range values are still converted and published, e.g. 63 gives tens 6, ones 3.
  - Next state is always IDLE.
- `freeze` is ignored in every state except IDLE.
- `clear` takes effect at the next clock edge from any state:
  - state goes to IDLE and the divider to 0;
  - all enables go to 0;
  - all digits, shadows, `frame_valid`, `range_err` and `busy` go to 0.
  - A scan interrupted by `clear` publishes nothing.

## Timing

- Reset values of all outputs: 0.
- After `clear` is released, the first SEC0 is entered after SCAN_DIV cycles in IDLE.
- A scan occupies 7 cycles: SEC0..HR1 (6) plus UPDATE (1).
- Steady-state frame period is SCAN_DIV+7 cycles, measured `frame_valid` to `frame_valid`.
- Capture latency: a `databus` value present during SEC1 appears on the digit outputs 5 cycles later, in the cycle after the UPDATE edge.
- Each enable is high for exactly 2 consecutive cycles per scan. The bus is sampled only at the second edge, so a counter that increments during the SEC0 settle cycle is read at its new value.
- Digits never tear: between `frame_valid` pulses, all six digit outputs are constant.
- `busy` is high from SEC0 through UPDATE inclusive.

## Test plan

- Reset and idle:
  - Assert `clear` for 2 cycles, SCAN_DIV=4.
  - All outputs are 0 during and after reset.
  - `en_sec` rises exactly 4 cycles after `clear` falls.
- Normal frame:
  - Bus model returns 59/59/23 under `en_sec`/`en_min`/`en_hr` respectively.
  - After `frame_valid`: sec 5,9; min 5,9; hr 2,3; `range_err`=0.
  - Period between `frame_valid` pulses is 11 cycles.
- Range error:
  - sec=60, min=0, hr=24 with HOUR_MAX=23.
  - Digits show 6,0; 0,0; 2,4 and `range_err`=1.
  - Next frame with in-range values clears `range_err`.
- Freeze:
  - Raise `freeze` mid-scan (during MIN0): the frame still completes with `frame_valid`.
  - No further SEC0 occurs while `freeze` is held.
  - SEC0 starts the cycle after `freeze` drops.
- Reset mid-scan:
  - Assert `clear` during HR0.
  - Enables drop next edge, no `frame_valid` pulse, digits return to 0.
- Enable exclusivity and sampling:
  - Change the bus value during SEC0: the value present in SEC1 is captured.
  - Assert throughout the run that at most one enable is high per cycle.

Source files
------------

// File: rtl/time_bus_reader.sv
// rtl/time_bus_reader.sv - scans seconds/minutes/hours off the shared databus and publishes BCD digits
module time_bus_reader #(
    parameter int SCAN_DIV = 1000,
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       freeze,
    input  logic [5:0] databus,
    output logic       en_sec,
    output logic       en_min,
    output logic       en_hr,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] hr_tens,
    output logic       frame_valid,
    output logic       range_err,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, SEC0, SEC1, MIN0, MIN1, HR0, HR1, UPDATE} state_t;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [5:0]  HR_LIM   = 6'(HOUR_MAX);

    state_t      state, state_nx;
    logic [15:0] div;
    logic [5:0]  sh_sec, sh_min;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] r;
        t = 4'd0;
        r = v[3:0];
        if (v >= 6'd60)      begin t = 4'd6; r = 4'(v - 6'd60); end
        else if (v >= 6'd50) begin t = 4'd5; r = 4'(v - 6'd50); end
        else if (v >= 6'd40) begin t = 4'd4; r = 4'(v - 6'd40); end
        else if (v >= 6'd30) begin t = 4'd3; r = 4'(v - 6'd30); end
        else if (v >= 6'd20) begin t = 4'd2; r = 4'(v - 6'd20); end
        else if (v >= 6'd10) begin t = 4'd1; r = 4'(v - 6'd10); end
        return {t, r};
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (div == DIV_LAST && !freeze) state_nx = SEC0;
            SEC0:    state_nx = SEC1;
            SEC1:    state_nx = MIN0;
            MIN0:    state_nx = MIN1;
            MIN1:    state_nx = HR0;
            HR0:     state_nx = HR1;
            HR1:     state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= IDLE;
            div         <= '0;
            en_sec      <= 1'b0;
            en_min      <= 1'b0;
            en_hr       <= 1'b0;
            busy        <= 1'b0;
            sh_sec      <= '0;
            sh_min      <= '0;
            sec_ones    <= '0;
            sec_tens    <= '0;
            min_ones    <= '0;
            min_tens    <= '0;
            hr_ones     <= '0;
            hr_tens     <= '0;
            frame_valid <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            state <= state_nx;
            // Divider only runs while idling; it saturates so a held freeze releases immediately.
            if (state != IDLE || state_nx != IDLE) div <= '0;
            else if (div != DIV_LAST)              div <= div + 16'd1;

            en_sec      <= (state_nx == SEC0) || (state_nx == SEC1);
            en_min      <= (state_nx == MIN0) || (state_nx == MIN1);
            en_hr       <= (state_nx == HR0)  || (state_nx == HR1);
            busy        <= (state_nx != IDLE);
            frame_valid <= (state == HR1);

            if (state == SEC1) sh_sec <= databus;
            if (state == MIN1) sh_min <= databus;
            // Hour value is taken straight off the bus on the HR1 edge so all six digits land together.
            if (state == HR1) begin
                {sec_tens, sec_ones} <= to_bcd(sh_sec);
                {min_tens, min_ones} <= to_bcd(sh_min);
                {hr_tens,  hr_ones}  <= to_bcd(databus);
                range_err <= (sh_sec > 6'd59) | (sh_min > 6'd59) | (databus > HR_LIM);
            end
        end
    end

endmodule

// File: tb/tb_time_bus_reader.sv
// tb/tb_time_bus_reader.sv - randomized and directed bench for time_bus_reader
module tb_time_bus_reader;

    localparam int SCAN_DIV = 4;
    localparam int HOUR_MAX = 23;

    logic       clk = 1'b0;
    logic       clear, freeze;
    logic [5:0] databus;
    logic       en_sec, en_min, en_hr, frame_valid, range_err, busy;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;

    logic [5:0] sv = 6'd0, mv = 6'd0, hv = 6'd0;
    int vectors = 0;
    int miscompares = 0;

    time_bus_reader #(.SCAN_DIV(SCAN_DIV), .HOUR_MAX(HOUR_MAX)) dut (
        .clk(clk), .clear(clear), .freeze(freeze), .databus(databus),
        .en_sec(en_sec), .en_min(en_min), .en_hr(en_hr),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
        .min_tens(min_tens), .hr_ones(hr_ones), .hr_tens(hr_tens),
        .frame_valid(frame_valid), .range_err(range_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Counter bank: each counter gates its value onto the OR bus under its own enable.
    assign databus = ({6{en_sec}} & sv) | ({6{en_min}} & mv) | ({6{en_hr}} & hv);

    wire [23:0] digits  = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
    wire [29:0] all_out = {en_sec, en_min, en_hr, busy, frame_valid, range_err, digits};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bcd(input logic [5:0] v);
        return ((int'(v) / 10) * 16) + (int'(v) % 10);
    endfunction

    task automatic check_frame(input string tag);
        chk({tag, "_sec"}, {24'd0, sec_tens, sec_ones}, bcd(sv));
        chk({tag, "_min"}, {24'd0, min_tens, min_ones}, bcd(mv));
        chk({tag, "_hr"},  {24'd0, hr_tens, hr_ones},   bcd(hv));
        chk({tag, "_range_err"}, range_err,
            32'((int'(sv) > 59) || (int'(mv) > 59) || (int'(hv) > HOUR_MAX)));
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!frame_valid && n < 300);
        if (!frame_valid) chk("frame_timeout", frame_valid, 1);
    endtask

    task automatic wait_en(input int which);
        int n;
        logic s;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            s = (which == 0) ? en_sec : (which == 1) ? en_min : en_hr;
        end while (!s && n < 300);
        if (!s) chk("enable_timeout", s, 1);
    endtask

    logic [23:0] prev_d;
    logic        prev_clr = 1'b1;
    always @(negedge clk) begin
        vectors++;
        assert ($onehot0({en_sec, en_min, en_hr})) else begin
            miscompares++;
            $error("FAIL enable_exclusive observed=%b expected=at_most_one", {en_sec, en_min, en_hr});
        end
        if (!frame_valid && !prev_clr) begin
            vectors++;
            assert (digits === prev_d) else begin
                miscompares++;
                $error("FAIL digit_tear observed=%h expected=%h", digits, prev_d);
            end
        end
        prev_d   = digits;
        prev_clr = clear;
    end

    initial begin
        int n, cnt;
        clear = 1'b1; freeze = 1'b0;
        sv = 6'd59; mv = 6'd59; hv = 6'd23;
        repeat (2) begin
            @(posedge clk); #1;
            chk("reset_outputs", {2'b0, all_out}, 0);
        end
        clear = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("en_sec_rise_c%0d", i), en_sec, 32'(i == 4));
        end
        chk("busy_in_sec0", busy, 1);

        wait_frame(n);
        check_frame("normal");
        wait_frame(n);
        chk("frame_period", n, 11);
        check_frame("normal2");

        sv = 6'd60; mv = 6'd0; hv = 6'd24;
        wait_frame(n);
        check_frame("range");
        sv = 6'd12; mv = 6'd34; hv = 6'd5;
        wait_frame(n);
        check_frame("inrange");

        for (int k = 0; k < 8; k++) begin
            sv = 6'($urandom_range(0, 63));
            mv = 6'($urandom_range(0, 63));
            hv = 6'($urandom_range(0, 63));
            wait_frame(n);
            check_frame($sformatf("rand%0d", k));
        end

        sv = 6'd7; mv = 6'd1; hv = 6'd2;
        wait_en(0);
        sv = 6'd48;
        wait_frame(n);
        check_frame("sec0_change");

        wait_en(1);
        freeze = 1'b1;
        wait_frame(n);
        check_frame("freeze_mid");
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            cnt += int'(en_sec) + int'(busy);
        end
        chk("freeze_no_scan", cnt, 0);
        freeze = 1'b0;
        @(posedge clk); #1;
        chk("freeze_release_sec0", en_sec, 1);

        sv = 6'd63; mv = 6'd63; hv = 6'd63;
        wait_frame(n);
        check_frame("max");

        wait_en(2);
        clear = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("midscan_reset_outputs", {2'b0, all_out}, 0);
        end
        clear = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midscan_no_frame", frame_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
